// File: rtl/pio_pkg.sv
// Shared constants and the edge-select helper for the Avalon PIO with edge-capture interrupt.
package pio_pkg;

  // Word addresses of the register map; 6 and 7 are unused holes.
  localparam logic [2:0] ADDR_OUT_DATA = 3'd0;
  localparam logic [2:0] ADDR_IN_DATA  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  // Capture edge encodings for the EDGE_TYPE parameter.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Warm-up counter width; holds SYNC_STAGES+1 for SYNC_STAGES up to 4.
  localparam int WARM_W = 3;

  // Per-bit edge detect between the current and previous synchronised sample.
  function automatic logic [31:0] edge_select(input int edge_type,
                                              input logic [31:0] cur,
                                              input logic [31:0] prev);
    logic [31:0] result;
    if (edge_type == EDGE_RISING) begin
      result = cur & ~prev;
    end else if (edge_type == EDGE_FALLING) begin
      result = ~cur & prev;
    end else begin
      result = cur ^ prev;
    end
    return result;
  endfunction

endpackage

// File: rtl/pio_edge_capture.sv
// Input synchroniser, edge detection with post-reset warm-up masking and
// write-one-to-clear edge capture register.
module pio_edge_capture
  import pio_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] in_port,
  input  logic [IN_WIDTH-1:0] w1c,
  output logic [IN_WIDTH-1:0] in_sync,
  output logic [IN_WIDTH-1:0] edge_cap
);

  // Warm-up lasts long enough for reset zeros to flush through the chain and prev.
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

  logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0] prev_q;
  logic [WARM_W-1:0]   warm_cnt;
  logic [31:0]         edge_wide;
  logic [IN_WIDTH-1:0] edge_now;
  logic                warm;
  logic                unused_edge_hi;

  assign in_sync        = sync_q[SYNC_STAGES-1];
  assign edge_wide      = edge_select(EDGE_TYPE, 32'(in_sync), 32'(prev_q));
  assign edge_now       = edge_wide[IN_WIDTH-1:0];
  assign unused_edge_hi = ^edge_wide;
  assign warm           = (warm_cnt != '0);

  // Shift asynchronous inputs through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Track previous sample, count down warm-up, and capture edges; a new edge beats W1C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q   <= '0;
      warm_cnt <= WARM_INIT;
      edge_cap <= '0;
    end else begin
      prev_q   <= in_sync;
      if (warm) warm_cnt <= warm_cnt - 1'b1;
      edge_cap <= (edge_cap & ~w1c) | (warm ? '0 : edge_now);
    end
  end

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM slave PIO: output register with atomic set/clear, synchronised
// input with edge capture, and a maskable level interrupt.
//
// Bus: every access is a single cycle with no wait states. At a clk edge with
// chipselect high, write_n low commits writedata and read_n low latches the
// selected register (pre-write value) onto readdata, which is valid exactly
// one cycle later and returns to zero on cycles without a read.
module avalon_pio_irq
  import pio_pkg::*;
#(
  parameter int                   OUT_WIDTH   = 8,
  parameter int                   IN_WIDTH    = 8,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET   = '0,
  parameter int                   EDGE_TYPE   = 0,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 read_n,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  logic                 wr;
  logic                 rd;
  logic [OUT_WIDTH-1:0] out_reg;
  logic [OUT_WIDTH-1:0] wd_out;
  logic [IN_WIDTH-1:0]  irq_mask;
  logic [IN_WIDTH-1:0]  w1c;
  logic [IN_WIDTH-1:0]  in_sync;
  logic [IN_WIDTH-1:0]  edge_cap;
  logic [31:0]          rd_data;
  logic                 unused_writedata;

  assign wr               = chipselect & ~write_n;
  assign rd               = chipselect & ~read_n;
  assign wd_out           = writedata[OUT_WIDTH-1:0];
  assign w1c              = (wr && address == ADDR_EDGE_CAP) ? writedata[IN_WIDTH-1:0] : '0;
  assign out_port         = out_reg;
  assign unused_writedata = ^writedata;

  pio_edge_capture #(
    .IN_WIDTH   (IN_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .w1c     (w1c),
    .in_sync (in_sync),
    .edge_cap(edge_cap)
  );

  // Select the register value as it stands before this edge's updates.
  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_OUT_DATA: rd_data[OUT_WIDTH-1:0] = out_reg;
      ADDR_IN_DATA:  rd_data[IN_WIDTH-1:0]  = in_sync;
      ADDR_IRQ_MASK: rd_data[IN_WIDTH-1:0]  = irq_mask;
      ADDR_EDGE_CAP: rd_data[IN_WIDTH-1:0]  = edge_cap;
      default:       rd_data = '0;
    endcase
  end

  // Output register (replace / set / clear) and interrupt mask writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_reg  <= OUT_RESET;
      irq_mask <= '0;
    end else if (wr) begin
      case (address)
        ADDR_OUT_DATA: out_reg  <= wd_out;
        ADDR_IRQ_MASK: irq_mask <= writedata[IN_WIDTH-1:0];
        ADDR_OUT_SET:  out_reg  <= out_reg | wd_out;
        ADDR_OUT_CLR:  out_reg  <= out_reg & ~wd_out;
        default:       ;
      endcase
    end
  end

  // Registered read data and level interrupt from the current capture and mask.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd ? rd_data : '0;
      irq      <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Self-checking bench for avalon_pio_irq: two instances (rising and any-edge
// capture) on a shared bus, checked every cycle against a behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_avalon_pio_irq;

  localparam int          OW      = 8;
  localparam int          IW      = 8;
  localparam int          S       = 2;
  localparam logic [7:0]  OUT_RST = 8'hA5;

  // ---------------- clock / reset / bus signals ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [IW-1:0] in_port = '0;

  logic [31:0]   readdata_r, readdata_a;
  logic [OW-1:0] out_port_r, out_port_a;
  logic          irq_r, irq_a;

  always #5 clk = ~clk;

  avalon_pio_irq #(.OUT_WIDTH(OW), .IN_WIDTH(IW), .OUT_RESET(OUT_RST),
                   .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_r), .in_port(in_port), .out_port(out_port_r), .irq(irq_r)
  );

  avalon_pio_irq #(.OUT_WIDTH(OW), .IN_WIDTH(IW), .OUT_RESET(OUT_RST),
                   .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_a), .in_port(in_port), .out_port(out_port_a), .irq(irq_a)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the rising-edge instance, index 1 the any-edge instance.
  logic [7:0]  m_out, m_mask;
  logic [7:0]  m_cap [2];
  logic        m_irq [2];
  logic [31:0] m_rd  [2];
  logic [7:0]  hist [$];   // hist[k] = in_port as sampled k+1 edges ago
  int          n_since;    // clocked edges since reset released
  bit          model_valid = 1'b0;

  function automatic logic [7:0] edges_of(input int kind, input logic [7:0] cur, input logic [7:0] prv);
    if (kind == 0) return cur & ~prv;
    else if (kind == 1) return ~cur & prv;
    else return cur ^ prv;
  endfunction

  always @(posedge clk) begin : model
    logic        rd_b, wr_b;
    logic [7:0]  cur, prv, wd8, w1c, ev;
    logic [31:0] rv;
    if (!reset_n) begin
      m_out = OUT_RST; m_mask = '0;
      for (int i = 0; i < 2; i++) begin m_cap[i] = '0; m_irq[i] = 1'b0; m_rd[i] = '0; end
      hist.delete();
      for (int i = 0; i <= S; i++) hist.push_back(8'h00);
      n_since = 0;
      model_valid = 1'b1;
    end else begin
      rd_b = chipselect && !read_n;
      wr_b = chipselect && !write_n;
      wd8  = writedata[7:0];
      cur  = hist[S-1];   // synchronised input: sampled S edges ago
      prv  = hist[S];     // one sample older
      w1c  = (wr_b && address == 3'd3) ? wd8 : 8'h00;
      for (int i = 0; i < 2; i++) begin
        case (address)
          3'd0:    rv = {24'h0, m_out};
          3'd1:    rv = {24'h0, cur};
          3'd2:    rv = {24'h0, m_mask};
          3'd3:    rv = {24'h0, m_cap[i]};
          default: rv = 32'h0;
        endcase
        m_rd[i]  = rd_b ? rv : 32'h0;
        m_irq[i] = |(m_cap[i] & m_mask);
        ev       = (n_since >= S + 1) ? edges_of(i == 0 ? 0 : 2, cur, prv) : 8'h00;
        m_cap[i] = (m_cap[i] & ~w1c) | ev;
      end
      if (wr_b) begin
        case (address)
          3'd0:    m_out = wd8;
          3'd2:    m_mask = wd8;
          3'd4:    m_out = m_out | wd8;
          3'd5:    m_out = m_out & ~wd8;
          default: ;
        endcase
      end
      hist.push_front(in_port);
      void'(hist.pop_back());
      if (n_since < 1000) n_since++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      check("out_port_rise", 32'(out_port_r), 32'(m_out));
      check("out_port_any",  32'(out_port_a), 32'(m_out));
      check("irq_rise",      32'(irq_r),      32'(m_irq[0]));
      check("irq_any",       32'(irq_a),      32'(m_irq[1]));
      check("readdata_rise", readdata_r,      m_rd[0]);
      check("readdata_any",  readdata_a,      m_rd[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; read_n = !r; write_n = !w; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 3'($urandom_range(0, 7)); writedata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;

    // Reset state and first read
    check("rst_out_port", 32'(out_port_r), 32'h0000_00A5);
    check("rst_readdata", readdata_r, 32'h0);
    check("rst_irq", 32'(irq_r), 32'h0);
    check("pin_model_out", 32'(m_out), 32'h0000_00A5);
    bus(1, 0, 3'd0, 32'h0);
    check("rd_out_data", readdata_r, 32'h0000_00A5);
    idle(1);
    check("rd_returns_zero", readdata_r, 32'h0);

    // Replace, set, clear
    bus(0, 1, 3'd0, 32'h0000_00F0);
    check("out_write", 32'(out_port_r), 32'h0000_00F0);
    bus(0, 1, 3'd4, 32'h0000_000F);
    check("out_set", 32'(out_port_r), 32'h0000_00FF);
    bus(0, 1, 3'd5, 32'h0000_0081);
    check("out_clr", 32'(out_port_r), 32'h0000_007E);
    check("pin_model_clr", 32'(m_out), 32'h0000_007E);
    bus(1, 0, 3'd4, 32'h0);
    check("rd_set_zero", readdata_r, 32'h0);
    bus(1, 0, 3'd5, 32'h0);
    check("rd_clr_zero", readdata_r, 32'h0);

    // Rising edge on bit0 with mask 01: capture at k+2, irq at k+3
    bus(0, 1, 3'd2, 32'h1);
    in_port = 8'h01;
    idle(2);
    check("irq_k1", 32'(irq_r), 32'h0);
    idle(1);
    check("irq_k2", 32'(irq_r), 32'h0);
    idle(1);
    check("irq_k3", 32'(irq_r), 32'h1);
    check("pin_model_irq", 32'(m_irq[0]), 32'h1);
    bus(1, 0, 3'd3, 32'h0);
    check("edge_cap_bit0", readdata_r, 32'h1);
    bus(0, 1, 3'd3, 32'h1);
    check("irq_w1c_same", 32'(irq_r), 32'h1);
    idle(1);
    check("irq_w1c_drop", 32'(irq_r), 32'h0);

    // Static high through reset is not captured; then falling bit3 on any-edge
    in_port = 8'hFF;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(6);
    bus(1, 0, 3'd3, 32'h0);
    check("warm_cap_rise", readdata_r, 32'h0);
    check("warm_cap_any", readdata_a, 32'h0);
    in_port = 8'hF7;
    idle(4);
    bus(1, 0, 3'd3, 32'h0);
    check("fall_cap_rise", readdata_r, 32'h0);
    check("fall_cap_any", readdata_a, 32'h08);
    check("pin_model_any", 32'(m_cap[1]), 32'h08);

    // New edge in the same cycle as its W1C; read with write returns pre-write value
    in_port = 8'hF4;
    idle(4);
    bus(0, 1, 3'd3, 32'hFF);
    idle(1);
    in_port = 8'hF6;
    idle(4);
    in_port = 8'hF7;
    idle(2);
    bus(1, 1, 3'd3, 32'h03);
    check("rdwr_prewrite_rise", readdata_r, 32'h02);
    check("rdwr_prewrite_any", readdata_a, 32'h02);
    bus(1, 0, 3'd3, 32'h0);
    check("edge_beats_w1c_rise", readdata_r, 32'h01);
    check("edge_beats_w1c_any", readdata_a, 32'h01);

    // Reset mid-capture with an in-flight read
    bus(0, 1, 3'd2, 32'h05);
    in_port = 8'hF2;
    idle(4);
    bus(0, 1, 3'd3, 32'hFF);
    in_port = 8'hF7;
    idle(4);
    check("mid_irq_set", 32'(irq_r), 32'h1);
    bus(1, 0, 3'd3, 32'h0);
    check("mid_cap_05", readdata_r, 32'h05);
    reset_n = 1'b0; chipselect = 1'b1; read_n = 1'b0; address = 3'd3;
    @(negedge clk);
    reset_n = 1'b1; chipselect = 1'b0; read_n = 1'b1;
    check("mid_rst_readdata", readdata_r, 32'h0);
    check("mid_rst_irq", 32'(irq_r), 32'h0);
    check("mid_rst_out", 32'(out_port_r), 32'h0000_00A5);
    bus(1, 0, 3'd2, 32'h0);
    check("mid_rst_mask", readdata_r, 32'h0);
    bus(1, 0, 3'd3, 32'h0);
    check("mid_rst_cap", readdata_r, 32'h0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom & $urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      read_n     = ($urandom_range(0, 1) == 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; reset_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
